alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Sequential initiator for the 16-bit combinational ALU (op_code/inputA/inputB -> R/error).
//  Accepts commands over a valid/ready handshake and drives the ALU with {acc, operand, op}.
//  Waits a fixed settle time, then captures R. Returns the result and a masked error code over a
//  valid/ready response channel. Keeps a 16-bit accumulator that is fed back as ALU inputA.
// PARAMETERS
//  SETTLE_CYCLES  2   cycles alu_* held stable before capture; legal range 1..15
//  CNT_W          4   settle counter width; must satisfy 2**CNT_W > SETTLE_CYCLES
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   sequencer can accept a command
//  cmd_op       in   4   ALU op code: 0 ADD,1 MOD,2 DIV,3 CLR,4 MUL,5 AND,6 OR,7 NAND,8 SUB,9 NOR,10 XOR,11 XNOR,12 NOT,15 PRESET
//  cmd_load     in   1   1: acc<=cmd_operand directly, no ALU issue
//  cmd_operand  in   16  ALU inputB, or load value
//  alu_a        out  16  to ALU inputA (= acc)
//  alu_b        out  16  to ALU inputB
//  alu_op       out  4   to ALU op_code
//  alu_r        in   32  ALU R
//  alu_error    in   1   ALU overflow flag
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   response consumed
//  rsp_result   out  32  captured R (load: zero-extended operand)
//  rsp_err      out  2   [1] divide-by-zero, [0] add/sub overflow
//  acc          out  16  accumulator
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; acc, alu_a, alu_b, rsp_result = 0; alu_op = 4'd3 (CLR); rsp_err, rsp_valid = 0; cmd_ready = 1.
//  FSM: IDLE -> ISSUE -> SETTLE -> CAPTURE -> RESP -> IDLE.
//   IDLE: cmd_ready=1. cmd_valid&cmd_ready with cmd_load=1 -> acc<=operand, rsp_result<={16'b0,operand},
//     rsp_err=0, go to RESP. A non-load command registers alu_b/alu_op and goes to ISSUE.
//   ISSUE: 1 cycle; clears the counter; alu_a/alu_b/alu_op are already stable.
//   SETTLE: counts to SETTLE_CYCLES-1. alu_* must not change until CAPTURE completes.
//   CAPTURE: 1 cycle. rsp_result<=alu_r.
//     rsp_err[0] <= alu_error & (op==0|op==8).
//     rsp_err[1] <= (op==1|op==2) & (alu_b==0).
//     acc <= alu_r[15:0], unless rsp_err[1] is set; in that case acc is held.
//   RESP: rsp_valid=1 and held until rsp_ready. The handshake cycle returns to IDLE.
//     rsp_result and rsp_err are stable while rsp_valid=1.
//  Latency for an ALU command: accept edge to rsp_valid = SETTLE_CYCLES+3 cycles (ISSUE, SETTLE, CAPTURE).
//  Load latency: 1 cycle.
//  cmd_ready=0 outside IDLE; there is no command buffering. A new command is accepted no earlier
//  than the cycle after the response handshake.
//  rsp_ready asserted with rsp_valid=0 is ignored.
//  rst mid-operation returns to the reset state immediately. A partially issued command is dropped
//  with no response.
//  Widths: acc wraps modulo 2**16; the upper 16 bits of R are visible only in rsp_result.
// CONFIGURATION
//  `ALU_SEQ_SATURATE_EN defined: when rsp_err[0]=1, acc <= 16'h7FFF if alu_a[15]==0, else 16'h8000.
//    rsp_result still carries the raw R.
//  Not defined: acc takes the wrapped alu_r[15:0] on overflow.
// STRUCTURE
//  Package alu_seq_pkg: localparams for op codes (OP_ADD..OP_PRESET), state encoding
//  (ST_IDLE..ST_RESP), ERR_OVF=0, ERR_DZ=1.
//  Flat module; no sub-module. Benches instantiate it with the BreadBoard ALU as the responder.
// TESTING
//  1 reset: rst pulse mid-SETTLE -> acc=0, rsp_valid=0, cmd_ready=1, alu_op=3 immediately.
//  2 load 6 then XOR 9 (op 10), SETTLE_CYCLES=2 -> rsp_valid 5 cycles after accept,
//    rsp_result=32'h0000000F, acc=15, rsp_err=0.
//  3 load 16'h7FFF, ADD 1 -> rsp_err=2'b01; acc=16'h8000.
//    With ALU_SEQ_SATURATE_EN, acc=16'h7FFF.
//  4 load 6, DIV 0 (op 2) -> rsp_err=2'b10, rsp_result=32'hFFFFFFFF, acc stays 6.
//  5 backpressure: rsp_ready low for 4 cycles -> rsp_valid/rsp_result stable; cmd_valid held high
//    meanwhile is not accepted until after the handshake.
//  6 load 6, MUL 9 (op 4) -> rsp_result=54, acc=54; then SUB 4 (op 8) -> acc=50, rsp_err=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM states and error bit positions shared by alu_cmd_sequencer and its benches
package alu_seq_pkg;
    localparam logic [3:0] OP_ADD = 4'd0, OP_MOD = 4'd1, OP_DIV = 4'd2, OP_CLR = 4'd3,
                           OP_MUL = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_NAND = 4'd7,
                           OP_SUB = 4'd8, OP_NOR = 4'd9, OP_XOR = 4'd10, OP_XNOR = 4'd11,
                           OP_NOT = 4'd12, OP_PRESET = 4'd15;
    localparam int ERR_OVF = 0, ERR_DZ = 1;
    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_SETTLE, ST_CAPTURE, ST_RESP} state_t;
endpackage

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front-end for a combinational ALU with a fed-back accumulator; `ALU_SEQ_SATURATE_EN clamps acc on add/sub overflow
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic        cmd_load,
    input  logic [15:0] cmd_operand,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_r,
    input  logic        alu_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_err,
    output logic [15:0] acc,
    output logic        busy
);
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic dz, ovf;
    logic [15:0] acc_next;
    // acc only moves at capture, so it doubles as a stable inputA for the whole issue window
    assign alu_a = acc;
    always_comb begin
        dz = (alu_op == OP_MOD || alu_op == OP_DIV) && alu_b == '0;
        ovf = alu_error && (alu_op == OP_ADD || alu_op == OP_SUB);
`ifdef ALU_SEQ_SATURATE_EN
        acc_next = dz ? acc : ovf ? (alu_a[15] ? 16'h8000 : 16'h7FFF) : alu_r[15:0];
`else
        acc_next = dz ? acc : alu_r[15:0];
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt <= '0;
            acc <= '0;
            alu_b <= '0;
            alu_op <= OP_CLR;
            rsp_result <= '0;
            rsp_err <= '0;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    cmd_ready <= 1'b0;
                    busy <= 1'b1;
                    if (cmd_load) begin
                        acc <= cmd_operand;
                        rsp_result <= {16'h0, cmd_operand};
                        rsp_err <= '0;
                        rsp_valid <= 1'b1;
                        state <= ST_RESP;
                    end else begin
                        alu_b <= cmd_operand;
                        alu_op <= cmd_op;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt <= '0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state <= ST_CAPTURE;
                           else cnt <= cnt + 1'b1;
                ST_CAPTURE: begin
                    rsp_result <= alu_r;
                    rsp_err[ERR_OVF] <= ovf;
                    rsp_err[ERR_DZ] <= dz;
                    acc <= acc_next;
                    rsp_valid <= 1'b1;
                    state <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: random commands against a transaction-level model, with a behavioural ALU as responder; honours `ALU_SEQ_SATURATE_EN
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;
    localparam int SETTLE = 2;
`ifdef ALU_SEQ_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_load = 1'b0, rsp_ready = 1'b0;
    logic [3:0] cmd_op = '0;
    logic [15:0] cmd_operand = '0;
    logic cmd_ready, alu_error, rsp_valid, busy;
    logic [15:0] alu_a, alu_b, acc;
    logic [3:0] alu_op;
    logic [31:0] alu_r, rsp_result;
    logic [1:0] rsp_err;
    int vectors = 0, miscompares = 0, cyc = 0;

    alu_cmd_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_load(cmd_load), .cmd_operand(cmd_operand), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_r(alu_r), .alu_error(alu_error), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err), .acc(acc), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // returns {error, R}; error flags signed add/sub overflow and, to exercise masking, MUL overflow
    function automatic logic [32:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        logic [15:0] s;
        logic [31:0] p;
        s = '0;
        p = 32'(a) * 32'(b);
        case (op)
            4'd0: begin s = a + b; return {(a[15] == b[15]) && (s[15] != a[15]), 32'(a) + 32'(b)}; end
            4'd1: return {1'b0, b == 0 ? 32'hFFFFFFFF : 32'(a % b)};
            4'd2: return {1'b0, b == 0 ? 32'hFFFFFFFF : 32'(a / b)};
            4'd4: return {|p[31:16], p};
            4'd5: return {17'h0, a & b};
            4'd6: return {17'h0, a | b};
            4'd7: return {17'h0, ~(a & b)};
            4'd8: begin s = a - b; return {(a[15] != b[15]) && (s[15] != a[15]), 16'h0, s}; end
            4'd9: return {17'h0, ~(a | b)};
            4'd10: return {17'h0, a ^ b};
            4'd11: return {17'h0, ~(a ^ b)};
            4'd12: return {17'h0, ~a};
            4'd15: return {1'b0, 32'hFFFFFFFF};
            default: return 33'h0;
        endcase
    endfunction

    assign {alu_error, alu_r} = alu_fn(alu_a, alu_b, alu_op);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // model: one outstanding transaction, response due a fixed number of cycles after acceptance
    always @(negedge clk) begin : cmp
        logic pend, ov, dz;
        logic [3:0] p_op;
        logic [15:0] p_b, p_acc, m_acc;
        logic [31:0] p_r, r;
        logic [1:0] p_e;
        int due;
        if (rst) begin
            pend = 1'b0;
            m_acc = '0;
        end else if (pend) begin
            if (cyc < due) begin
                chk("busy", busy, 1);
                chk("cmd_ready_busy", cmd_ready, 0);
                chk("early_rsp_valid", rsp_valid, 0);
                chk("alu_a", alu_a, m_acc);
                chk("alu_b", alu_b, p_b);
                chk("alu_op", alu_op, p_op);
            end else begin
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_result", rsp_result, p_r);
                chk("rsp_err", rsp_err, p_e);
                chk("acc_resp", acc, p_acc);
                chk("cmd_ready_resp", cmd_ready, 0);
                if (rsp_valid && rsp_ready) begin
                    pend = 1'b0;
                    m_acc = p_acc;
                end
            end
        end else begin
            chk("idle_busy", busy, 0);
            chk("idle_cmd_ready", cmd_ready, 1);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_acc", acc, m_acc);
            if (cmd_valid) begin
                pend = 1'b1;
                if (cmd_load) begin
                    p_r = {16'h0, cmd_operand};
                    p_e = 2'b00;
                    p_acc = cmd_operand;
                    due = cyc + 1;
                end else begin
                    {ov, r} = alu_fn(m_acc, cmd_operand, cmd_op);
                    dz = (cmd_op == OP_MOD || cmd_op == OP_DIV) && cmd_operand == 0;
                    p_e = {dz, ov && (cmd_op == OP_ADD || cmd_op == OP_SUB)};
                    p_acc = dz ? m_acc : (p_e[0] && SAT) ? (m_acc[15] ? 16'h8000 : 16'h7FFF) : r[15:0];
                    p_r = r;
                    p_b = cmd_operand;
                    p_op = cmd_op;
                    due = cyc + SETTLE + 3;
                end
            end
        end
    end

    task automatic run_cmd(input logic ld, input logic [3:0] op, input logic [15:0] v, input int bp,
                           input logic hold, output logic [31:0] r, output logic [1:0] e, output int lat);
        int n, t0, vc;
        bit first, done;
        r = '0; e = '0; lat = -1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_operand = v;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: cmd_ready low for %0d cycles, required 1", n);
        end
        t0 = cyc;
        first = 1'b1; done = 1'b0; vc = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (i == 0 && !hold) cmd_valid = 1'b0;
            rsp_ready = rsp_valid ? (vc >= bp && ($urandom_range(0, 2) != 0 || vc >= bp + 2))
                                  : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rsp_valid) begin
                if (first) begin lat = cyc - t0; r = rsp_result; e = rsp_err; first = 1'b0; end
                if (rsp_ready) done = 1'b1; else vc++;
            end
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL rsp_timeout: no handshake within 100 cycles, required one");
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [1:0] e;
        int lat;
        logic [3:0] ops [14];
        logic ld;
        logic [3:0] op;
        logic [15:0] v;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
        #12;
        chk("reset_acc", acc, 0);
        chk("reset_alu_op", alu_op, 3);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_result", rsp_result, 0);
        @(posedge clk); #1 rst = 1'b0;

        run_cmd(1, 0, 16'd6, 0, 0, r, e, lat);
        chk("t2_load_lat", lat, 1);
        chk("t2_load_res", r, 32'h6);
        run_cmd(0, OP_XOR, 16'd9, 0, 0, r, e, lat);
        chk("t2_xor_lat", lat, 5);
        chk("t2_xor_res", r, 32'h0000000F);
        chk("t2_xor_err", e, 2'b00);
        chk("t2_acc", acc, 15);

        run_cmd(1, 0, 16'h7FFF, 0, 0, r, e, lat);
        run_cmd(0, OP_ADD, 16'd1, 0, 0, r, e, lat);
        chk("t3_err", e, 2'b01);
        chk("t3_res", r, 32'h00008000);
        chk("t3_acc", acc, SAT ? 16'h7FFF : 16'h8000);

        run_cmd(1, 0, 16'd6, 0, 0, r, e, lat);
        run_cmd(0, OP_DIV, 16'd0, 0, 0, r, e, lat);
        chk("t4_err", e, 2'b10);
        chk("t4_res", r, 32'hFFFFFFFF);
        chk("t4_acc", acc, 6);

        run_cmd(0, OP_OR, 16'h0030, 4, 1, r, e, lat);
        chk("t5_lat", lat, 5);
        chk("t5_res", r, 32'h36);

        run_cmd(1, 0, 16'd6, 0, 0, r, e, lat);
        run_cmd(0, OP_MUL, 16'd9, 0, 0, r, e, lat);
        chk("t6_mul_res", r, 32'd54);
        chk("t6_mul_acc", acc, 54);
        run_cmd(0, OP_SUB, 16'd4, 0, 0, r, e, lat);
        chk("t6_sub_acc", acc, 50);
        chk("t6_sub_err", e, 2'b00);

        run_cmd(1, 0, 16'd5, 0, 0, r, e, lat);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_ADD; cmd_operand = 16'd3;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("t1_rst_acc", acc, 0);
        chk("t1_rst_rsp_valid", rsp_valid, 0);
        chk("t1_rst_cmd_ready", cmd_ready, 1);
        chk("t1_rst_alu_op", alu_op, 3);
        chk("t1_rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int k = 0; k < 250; k++) begin
            ld = $urandom_range(0, 3) == 0;
            op = ops[$urandom_range(0, 13)];
            v = $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom);
            run_cmd(ld, op, v, $urandom_range(0, 3), 1'($urandom_range(0, 1)), r, e, lat);
            chk("rand_lat", lat, ld ? 1 : SETTLE + 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
